// File: rtl/vpu_pkg.sv
// Shared types and sizing helpers for the VPU sequencing controllers.
package vpu_pkg;

    localparam int unsigned DEF_R_PORTS     = 3;
    localparam int unsigned DEF_MAX_PHASES  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GETOP = 3'd1,
        S_EXEC  = 3'd2,
        S_WB    = 3'd3,
        S_ERR   = 3'd4
    } vpu_seq_state_t;

    function automatic int unsigned ph_w(input int unsigned max_phases);
        return (max_phases < 1) ? 1 : $clog2(max_phases + 1);
    endfunction

    // A zero timeout disables the watchdog but still needs a 1-bit counter.
    function automatic int unsigned to_w(input int unsigned timeout_cyc);
        return (timeout_cyc < 1) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/vpu_watchdog.sv
// Per-state stall counter: counts enabled cycles since the last clear and flags expiry
// on the cycle that would reach the limit. A limit of zero never expires.
module vpu_watchdog #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit;

    // Extra bit so the comparison never wraps at the top of the counter range.
    assign at_limit = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == {1'b0, limit_i});
    assign expire_o = en_i && (limit_i != '0) && at_limit;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !at_limit) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vpu_seq_ctrl.sv
// VPU request sequencer: one request at a time through operand fetch, N exec phases and
// writeback, with a per-state watchdog that traps into an error state.
module vpu_seq_ctrl
    import vpu_pkg::*;
#(
    parameter int unsigned  R_PORTS     = DEF_R_PORTS,
    parameter int unsigned  MAX_PHASES  = DEF_MAX_PHASES,
    parameter int unsigned  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int unsigned PH_W        = ph_w(MAX_PHASES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_i,
    input  logic [R_PORTS-1:0] req_port_mask_i,
    input  logic [PH_W-1:0]    req_nphase_i,
    output logic               req_rden_o,
    input  logic [R_PORTS-1:0] opget_done_i,
    output logic [R_PORTS-1:0] operand_rden_o,
    output logic               exec_start_o,
    input  logic               exec_done_i,
    output logic               wb_start_o,
    input  logic               wb_done_i,
    output logic               reset_cmd_o,
    input  logic               err_clr_i,
    output logic               busy_o,
    output logic               err_o,
    output logic [PH_W-1:0]    phase_o
);

    localparam int unsigned     TO_W     = to_w(TIMEOUT_CYC);
    localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0] PH_MAX   = PH_W'(MAX_PHASES);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYC);

    vpu_seq_state_t     state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [PH_W-1:0]    nphase_q, nphase_d;
    logic [R_PORTS-1:0] mask_q, mask_d;
    logic               first_q, first_d;

    logic ops_ready;
    logic last_phase;
    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    assign ops_ready  = ((opget_done_i & mask_q) == mask_q);
    assign last_phase = (phase_q == (nphase_q - PH_ONE));
    assign wd_en      = (state_q == S_GETOP) || (state_q == S_EXEC) || (state_q == S_WB);

    vpu_watchdog #(
        .CNT_W (TO_W)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wd_clr),
        .en_i     (wd_en),
        .limit_i  (TO_LIMIT),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            nphase_q <= '0;
            mask_q   <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            nphase_q <= nphase_d;
            mask_q   <= mask_d;
            first_q  <= first_d;
        end
    end

    // Progress is tested before expiry in every state, so a done on the limit cycle wins.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        nphase_d = nphase_q;
        mask_d   = mask_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    mask_d  = req_port_mask_i;
                    state_d = S_GETOP;
                    if (req_nphase_i == '0) begin
                        nphase_d = PH_ONE;
                    end else if (req_nphase_i > PH_MAX) begin
                        nphase_d = PH_MAX;
                    end else begin
                        nphase_d = req_nphase_i;
                    end
                end
            end
            S_GETOP: begin
                if (ops_ready) begin
                    state_d = S_EXEC;
                end else if (wd_expire) begin
                    state_d = S_ERR;
                end
            end
            S_EXEC: begin
                if (exec_done_i) begin
                    if (last_phase) begin
                        phase_d = '0;
                        state_d = S_WB;
                    end else begin
                        phase_d = phase_q + PH_ONE;
                    end
                end else if (wd_expire) begin
                    phase_d = '0;
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                if (wb_done_i) begin
                    state_d = S_IDLE;
                end else if (wd_expire) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (err_clr_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
        first_d = (state_d != state_q) || (phase_d != phase_q);
        wd_clr  = first_d;
    end

    // Pulses are gated by rst_n so nothing fires in a cycle that is being reset.
    always_comb begin
        req_rden_o     = 1'b0;
        operand_rden_o = '0;
        exec_start_o   = 1'b0;
        wb_start_o     = 1'b0;
        reset_cmd_o    = 1'b0;
        busy_o         = (state_q != S_IDLE);
        err_o          = (state_q == S_ERR);
        phase_o        = phase_q;
        if (rst_n) begin
            unique case (state_q)
                S_EXEC: begin
                    exec_start_o = first_q;
                    if (exec_done_i) begin
                        operand_rden_o = mask_q;
                    end
                end
                S_WB: begin
                    wb_start_o = first_q;
                    if (wb_done_i) begin
                        reset_cmd_o = 1'b1;
                        req_rden_o  = 1'b1;
                    end
                end
                S_ERR: begin
                    if (err_clr_i) begin
                        reset_cmd_o = 1'b1;
                        req_rden_o  = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_seq_ctrl.sv
// Self-checking bench for vpu_seq_ctrl: retire records are scoreboarded against per-request
// expectations, with inline checks for latency, watchdog and reset behaviour.
module tb_vpu_seq_ctrl;

    localparam int unsigned R    = 3;
    localparam int unsigned MAXP = 4;
    localparam int unsigned TO   = 8;
    localparam int unsigned PW   = 3;

    logic          clk             = 1'b0;
    logic          rst_n           = 1'b0;
    logic          req_valid_i     = 1'b0;
    logic [R-1:0]  req_port_mask_i = '0;
    logic [PW-1:0] req_nphase_i    = '0;
    logic [R-1:0]  opget_done_i    = '1;
    logic          exec_done_i     = 1'b1;
    logic          wb_done_i       = 1'b1;
    logic          err_clr_i       = 1'b0;
    logic          req_rden_o;
    logic [R-1:0]  operand_rden_o;
    logic          exec_start_o;
    logic          wb_start_o;
    logic          reset_cmd_o;
    logic          busy_o;
    logic          err_o;
    logic [PW-1:0] phase_o;

    always #5 clk = ~clk;

    vpu_seq_ctrl #(
        .R_PORTS     (R),
        .MAX_PHASES  (MAXP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .req_port_mask_i (req_port_mask_i),
        .req_nphase_i    (req_nphase_i),
        .req_rden_o      (req_rden_o),
        .opget_done_i    (opget_done_i),
        .operand_rden_o  (operand_rden_o),
        .exec_start_o    (exec_start_o),
        .exec_done_i     (exec_done_i),
        .wb_start_o      (wb_start_o),
        .wb_done_i       (wb_done_i),
        .reset_cmd_o     (reset_cmd_o),
        .err_clr_i       (err_clr_i),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .phase_o         (phase_o)
    );

    typedef struct {
        int           starts;
        logic [R-1:0] mask;
        int           n_oprd;
        logic         rc;
    } rec_t;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   checks = 0;
    int   errors = 0;

    int           mon_start   = 0;
    int           mon_oprd    = 0;
    logic [R-1:0] mon_or      = '0;
    int           n_req_rden  = 0;
    int           n_reset_cmd = 0;
    int           n_wb_start  = 0;
    int           n_busy_rise = 0;
    logic         busy_prev   = 1'b0;

    // Collects one record per request-queue pop; the tasks compare them.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_start <= 0;
            mon_oprd  <= 0;
            mon_or    <= '0;
            busy_prev <= 1'b0;
        end else begin
            if (exec_start_o) mon_start <= mon_start + 1;
            if (operand_rden_o != '0) begin
                mon_oprd <= mon_oprd + 1;
                mon_or   <= mon_or | operand_rden_o;
            end
            if (wb_start_o) n_wb_start <= n_wb_start + 1;
            if (reset_cmd_o) n_reset_cmd <= n_reset_cmd + 1;
            if (busy_o && !busy_prev) n_busy_rise <= n_busy_rise + 1;
            busy_prev <= busy_o;
            if (req_rden_o) begin
                n_req_rden <= n_req_rden + 1;
                obs_q.push_back('{mon_start, mon_or, mon_oprd, reset_cmd_o});
                mon_start <= 0;
                mon_oprd  <= 0;
                mon_or    <= '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Called at posedge+1; presents a request and returns at posedge+1 after its retire.
    task automatic send_req(input logic [R-1:0] m, input logic [PW-1:0] np, input int exp_st,
                            input bit last, output int cyc);
        rec_t e;
        e.starts = exp_st;
        e.mask   = m;
        e.n_oprd = (m != '0) ? exp_st : 0;
        e.rc     = 1'b1;
        exp_q.push_back(e);
        req_valid_i     = 1'b1;
        req_port_mask_i = m;
        req_nphase_i    = np;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req_rden_o) break;
        end
        @(posedge clk);
        #1;
        if (last) req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_rden_o, operand_rden_o, exec_start_o, wb_start_o, reset_cmd_o} !== '0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 0",
                     {req_rden_o, operand_rden_o, exec_start_o, wb_start_o, reset_cmd_o});
        end
        checks++;
        if ({busy_o, err_o, phase_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b err=%b phase=%0d, expected 0 0 0",
                     busy_o, err_o, phase_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, err_o, phase_o, req_rden_o, reset_cmd_o} !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b err=%b phase=%0d, expected idle with no pulses",
                     busy_o, err_o, phase_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        rec_t e, o;
        int cyc, d_rden, d_wb, d_rc;
        d_rden = n_req_rden;
        d_wb   = n_wb_start;
        d_rc   = n_reset_cmd;
        send_req(3'b111, 3'd2, 2, 1'b1, cyc);
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL t1_latency: got %0d cycles, expected 5", cyc);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL t1_sb: no retire observed, expected starts=%0d", e.starts);
        end else begin
            o = obs_q.pop_front();
            if (o.starts != e.starts || o.mask !== e.mask || o.n_oprd != e.n_oprd
                || o.rc !== e.rc) begin
                errors++;
                $display("FAIL t1_sb: got st=%0d m=%b rd=%0d rc=%b, expected st=%0d m=%b rd=%0d rc=%b",
                         o.starts, o.mask, o.n_oprd, o.rc, e.starts, e.mask, e.n_oprd, e.rc);
            end
        end
        checks++;
        if ({n_req_rden - d_rden, n_wb_start - d_wb, n_reset_cmd - d_rc} !== {32'd1, 32'd1, 32'd1})
        begin
            errors++;
            $display("FAIL t1_counts: rden=%0d wb_start=%0d reset_cmd=%0d, expected 1 1 1",
                     n_req_rden - d_rden, n_wb_start - d_wb, n_reset_cmd - d_rc);
        end
    endtask

    task automatic test_mask();
        rec_t e, o;
        int cyc;
        logic [R-1:0] masks [2];
        masks[0] = 3'b101;
        masks[1] = 3'b000;
        for (int i = 0; i < 2; i++) begin
            opget_done_i = masks[i];
            send_req(masks[i], 3'd1, 1, 1'b1, cyc);
            checks++;
            if (cyc != 4) begin
                errors++;
                $display("FAIL t2_latency[%0d]: got %0d cycles, expected 4", i, cyc);
            end
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t2_sb[%0d]: no retire observed, expected mask=%b", i, e.mask);
            end else begin
                o = obs_q.pop_front();
                if (o.starts != e.starts || o.mask !== e.mask || o.n_oprd != e.n_oprd
                    || o.rc !== e.rc) begin
                    errors++;
                    $display("FAIL t2_sb[%0d]: got st=%0d m=%b rd=%0d, expected st=%0d m=%b rd=%0d",
                             i, o.starts, o.mask, o.n_oprd, e.starts, e.mask, e.n_oprd);
                end
            end
        end
        opget_done_i = '1;
    endtask

    task automatic test_nphase();
        rec_t e, o;
        int cyc;
        send_req(3'b011, 3'd0, 1, 1'b1, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL t3_np0_latency: got %0d cycles, expected 4", cyc);
        end
        send_req(3'b110, 3'd7, 4, 1'b1, cyc);
        checks++;
        if (cyc != 7) begin
            errors++;
            $display("FAIL t3_np7_latency: got %0d cycles, expected 7", cyc);
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t3_sb[%0d]: no retire observed, expected starts=%0d", i, e.starts);
            end else begin
                o = obs_q.pop_front();
                if (o.starts != e.starts || o.mask !== e.mask || o.n_oprd != e.n_oprd) begin
                    errors++;
                    $display("FAIL t3_sb[%0d]: got st=%0d m=%b rd=%0d, expected st=%0d m=%b rd=%0d",
                             i, o.starts, o.mask, o.n_oprd, e.starts, e.mask, e.n_oprd);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        rec_t e, o;
        bit seen;
        // Stall in WB until the watchdog traps, then acknowledge.
        e = '{1, 3'b001, 1, 1'b1};
        exp_q.push_back(e);
        wb_done_i       = 1'b0;
        req_valid_i     = 1'b1;
        req_port_mask_i = 3'b001;
        req_nphase_i    = 3'd1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = wb_start_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL t4_wb_start: wb_start_o=0 after 20 cycles, expected 1");
        end
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (err_o !== 1'(k == 8)) begin
                errors++;
                $display("FAIL t4_err_rise[%0d]: got err_o=%b, expected %b", k, err_o, k == 8);
            end
        end
        @(posedge clk);
        #1;
        err_clr_i   = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_rden_o, reset_cmd_o, err_o} !== 3'b111) begin
            errors++;
            $display("FAIL t4_clr_pulse: rden/rc/err=%b, expected 111",
                     {req_rden_o, reset_cmd_o, err_o});
        end
        @(posedge clk);
        #1;
        err_clr_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, err_o, req_rden_o} !== 3'b000) begin
            errors++;
            $display("FAIL t4_back_idle: busy/err/rden=%b, expected 000",
                     {busy_o, err_o, req_rden_o});
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL t4_sb_err: no drop record, expected starts=%0d", e.starts);
        end else begin
            o = obs_q.pop_front();
            if (o.starts != e.starts || o.mask !== e.mask || o.rc !== e.rc) begin
                errors++;
                $display("FAIL t4_sb_err: got st=%0d m=%b rc=%b, expected st=%0d m=%b rc=%b",
                         o.starts, o.mask, o.rc, e.starts, e.mask, e.rc);
            end
        end
        @(posedge clk);
        #1;
        // Done arriving on the limit cycle must win over the trap.
        e = '{1, 3'b100, 1, 1'b1};
        exp_q.push_back(e);
        req_valid_i     = 1'b1;
        req_port_mask_i = 3'b100;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = wb_start_o;
        end
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        wb_done_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({err_o, req_rden_o} !== 2'b01) begin
            errors++;
            $display("FAIL t4_limit_done: err/rden=%b, expected 01", {err_o, req_rden_o});
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, err_o} !== 2'b00) begin
            errors++;
            $display("FAIL t4_limit_idle: busy/err=%b, expected 00", {busy_o, err_o});
        end
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL t4_sb_ok: no retire observed, expected mask=%b", e.mask);
        end else begin
            o = obs_q.pop_front();
            if (o.starts != e.starts || o.mask !== e.mask || o.n_oprd != e.n_oprd) begin
                errors++;
                $display("FAIL t4_sb_ok: got st=%0d m=%b rd=%0d, expected st=%0d m=%b rd=%0d",
                         o.starts, o.mask, o.n_oprd, e.starts, e.mask, e.n_oprd);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        rec_t e, o;
        bit seen;
        int cyc;
        e = '{3, 3'b011, 3, 1'b1};
        exp_q.push_back(e);
        exec_done_i     = 1'b0;
        req_valid_i     = 1'b1;
        req_port_mask_i = 3'b011;
        req_nphase_i    = 3'd3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = exec_start_o;
        end
        @(posedge clk);
        #1;
        exec_done_i = 1'b1;
        @(posedge clk);
        #1;
        exec_done_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({phase_o, exec_start_o} !== {3'd1, 1'b1}) begin
            errors++;
            $display("FAIL t5_phase1: phase=%0d start=%b, expected 1 1", phase_o, exec_start_o);
        end
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        exec_done_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({operand_rden_o, exec_start_o, wb_start_o, req_rden_o, reset_cmd_o} !== '0) begin
            errors++;
            $display("FAIL t5_rst_cycle: pulses=%b, expected 0",
                     {operand_rden_o, exec_start_o, wb_start_o, req_rden_o, reset_cmd_o});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, err_o, phase_o, operand_rden_o, exec_start_o, wb_start_o, req_rden_o,
             reset_cmd_o} !== '0) begin
            errors++;
            $display("FAIL t5_after_rst: busy=%b err=%b phase=%0d, expected all outputs 0",
                     busy_o, err_o, phase_o);
        end
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (req_rden_o) break;
        end
        checks++;
        if (cyc != 5) begin
            errors++;
            $display("FAIL t5_reprocess: retire after %0d cycles, expected 5", cyc);
        end
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL t5_sb: no retire observed, expected starts=%0d", e.starts);
        end else begin
            o = obs_q.pop_front();
            if (o.starts != e.starts || o.mask !== e.mask || o.n_oprd != e.n_oprd) begin
                errors++;
                $display("FAIL t5_sb: got st=%0d m=%b rd=%0d, expected st=%0d m=%b rd=%0d",
                         o.starts, o.mask, o.n_oprd, e.starts, e.mask, e.n_oprd);
            end
        end
    endtask

    task automatic test_back_to_back();
        rec_t e, o;
        int cyc, d_rden, d_busy;
        logic [R-1:0]  masks [3];
        logic [PW-1:0] nps   [3];
        masks[0] = 3'b001; nps[0] = 3'd1;
        masks[1] = 3'b010; nps[1] = 3'd2;
        masks[2] = 3'b100; nps[2] = 3'd3;
        d_rden = n_req_rden;
        d_busy = n_busy_rise;
        for (int i = 0; i < 3; i++) begin
            send_req(masks[i], nps[i], i + 1, i == 2, cyc);
            checks++;
            if (cyc != i + 4) begin
                errors++;
                $display("FAIL t6_latency[%0d]: got %0d cycles, expected %0d", i, cyc, i + 4);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL t6_sb[%0d]: no retire observed, expected mask=%b", i, e.mask);
            end else begin
                o = obs_q.pop_front();
                if (o.starts != e.starts || o.mask !== e.mask || o.n_oprd != e.n_oprd) begin
                    errors++;
                    $display("FAIL t6_sb[%0d]: got st=%0d m=%b rd=%0d, expected st=%0d m=%b rd=%0d",
                             i, o.starts, o.mask, o.n_oprd, e.starts, e.mask, e.n_oprd);
                end
            end
        end
        checks++;
        if (n_req_rden - d_rden != 3 || n_busy_rise - d_busy != 3) begin
            errors++;
            $display("FAIL t6_counts: rden=%0d busy_rises=%0d, expected 3 3",
                     n_req_rden - d_rden, n_busy_rise - d_busy);
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d extra retires, expected 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_nphase();
        test_watchdog();
        test_reset_mid();
        @(posedge clk);
        #1;
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
